alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 64, operand/result width in bits.
REQ-002 Ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  2  requester 0 opcode: 0 ADD, 1 SUB, 2 AND, 3 XOR.
- req0_a, req0_b  in  W  requester 0 operands (signed two's complement).
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that owns the result.
- rsp_result  out  W  ALU result.
- rsp_cc  out  3  condition codes {ZF,SF,OF}.

Function
REQ-003 The block SHALL share one ALU between two requesters with FSM states IDLE, EXEC, DONE.
REQ-004 Transfer rule: a transfer occurs when reqN_valid and reqN_ready are both high at a rising edge; requesters hold valid, op and operands stable until the transfer.
REQ-005 reqN_ready is combinational and high only in IDLE, for at most one requester per cycle.
REQ-006 Arbitration in IDLE:
- One requester valid: that requester is granted.
- Both valid: the requester holding the priority pointer is granted.
REQ-007 After each transfer, the priority pointer points to the non-granted requester (round-robin).
REQ-008 IDLE->EXEC on transfer: op, a, b and the granted id are registered.
REQ-009 EXEC->DONE unconditionally after one cycle: result and cc are registered.
REQ-010 DONE->IDLE on rsp_valid&&rsp_ready.
REQ-011 rsp_valid is high exactly in DONE; rsp_valid rises two rising edges after the transfer edge.
REQ-012 While in DONE with rsp_ready low, rsp_id, rsp_result and rsp_cc are held stable and no request is accepted.
REQ-013 Arithmetic, truncated to W bits:
- ADD = a+b; SUB = a-b; AND = a&b; XOR = a^b.
REQ-014 Condition codes:
- ZF = (result==0); SF = result[W-1].
- OF for ADD: set when a and b have the same sign and result sign differs.
- OF for SUB: set when a and b signs differ and result sign differs from a.
- OF = 0 for AND and XOR.
REQ-015 Back-to-back operation: minimum spacing between transfers is 3 cycles, a new grant occurring in the IDLE cycle following the response handshake.
REQ-016 A requester whose valid drops before grant is simply not granted; the priority pointer is unchanged.

Reset
REQ-017 rst_n low SHALL immediately, without a clock edge, force the following, from any state including mid-EXEC or DONE:
- state=IDLE; priority pointer=requester 0.
- rsp_valid=0; rsp_id=0; rsp_result=0; rsp_cc=0.
- All internal operand registers cleared.
REQ-018 The first rising edge after rst_n deasserts SHALL be able to accept a transfer.

Structure
REQ-019 Opcode constants (ADD/SUB/AND/XOR), FSM state encodings and cc bit positions SHALL reside in a shared package alu_pkg.
REQ-020 The combinational datapath (op, a, b -> result, cc) SHALL be a single sub-module alu_core, instantiated once; the arbiter and FSM remain in alu_arbiter.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- req0 AND a=b=0x8000000000000000 -> rsp_result 0x8000000000000000, cc {0,1,0}, rsp_id 0, rsp_valid 2 edges after transfer.
- req1 AND a=0x7FFFFFFFFFFFFFFF b=0x8000000000000000 -> result 0, cc {1,0,0}, rsp_id 1.
- ADD a=0x7FFFFFFFFFFFFFFF b=1 -> result 0x8000000000000000, cc {0,1,1}; SUB a=0x8000000000000000 b=1 -> 0x7FFFFFFFFFFFFFFF, cc {0,0,1}.
- Both valid right after reset, AND a=-1 b=0x8000000000000000 on both -> req0 granted first, then req1; rsp_id sequence 0,1; both results 0x8000000000000000.
- rsp_ready held low 3 cycles in DONE -> outputs stable, both reqN_ready low, and the transfer occurs in the IDLE cycle after the handshake.
- rst_n pulsed low during EXEC -> rsp_valid=0 and rsp_result=0 immediately; the pending operation is discarded; the next grant goes to req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - alu_op_e    : opcode encoding seen on reqN_op
//   - arb_state_e : arbiter FSM state encoding
//   - CC_*        : bit positions inside the 3-bit condition-code vector {ZF,SF,OF}
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam int CC_W  = 3;
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (op, a, b) -> (result, cc).
// Ports:
//   op_i     : operation (ADD/SUB/AND/XOR)
//   a_i, b_i : signed two's-complement operands, W bits
//   result_o : result truncated to W bits
//   cc_o     : condition codes {ZF,SF,OF}
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  alu_op_e         op_i,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    output logic [W-1:0]    result_o,
    output logic [CC_W-1:0] cc_o
);

    logic [W-1:0] res;
    logic         ovf;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op_i)
            OP_ADD: begin
                res = a_i + b_i;
                // Operands agree in sign but the sum does not.
                ovf = (a_i[W-1] == b_i[W-1]) && (res[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                res = a_i - b_i;
                // Operands differ in sign and the difference left a's sign.
                ovf = (a_i[W-1] != b_i[W-1]) && (res[W-1] != a_i[W-1]);
            end
            OP_AND:  res = a_i & b_i;
            default: res = a_i ^ b_i;
        endcase
    end

    assign result_o     = res;
    assign cc_o[CC_ZF]  = (res == '0);
    assign cc_o[CC_SF]  = res[W-1];
    assign cc_o[CC_OF]  = ovf;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration.
// FSM: IDLE (accept one request) -> EXEC (compute, register result)
//      -> DONE (present result until rsp_ready) -> IDLE.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/op/a/b           : request from requester N (N = 0, 1)
//   reqN_ready                  : combinational accept, only in IDLE
//   rsp_valid/rsp_ready         : response handshake
//   rsp_id, rsp_result, rsp_cc  : owner, result and {ZF,SF,OF} of the response
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic [1:0]      req0_op,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [1:0]      req1_op,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic            req1_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_result,
    output logic [CC_W-1:0] rsp_cc
);

    arb_state_e      state_q, state_d;
    logic            prio_q, prio_d;   // requester that wins a tie
    alu_op_e         op_q;
    logic [W-1:0]    a_q, b_q;
    logic            id_q;
    logic [W-1:0]    result_q;
    logic [CC_W-1:0] cc_q;

    logic [W-1:0]    alu_result;
    logic [CC_W-1:0] alu_cc;
    logic            xfer;
    logic            grant_id;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req0_ready = req0_valid && (!req1_valid || !prio_q);
                req1_ready = req1_valid && (!req0_valid ||  prio_q);
                if (req0_ready || req1_ready) begin
                    state_d = ST_EXEC;
                    // Pointer moves to the requester that lost this round.
                    prio_d  = req0_ready;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready already implies valid, so either ready alone marks a transfer.
    assign xfer     = req0_ready || req1_ready;
    assign grant_id = req1_ready;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            cc_q     <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (xfer) begin
                op_q <= grant_id ? alu_op_e'(req1_op) : alu_op_e'(req0_op);
                a_q  <= grant_id ? req1_a : req0_a;
                b_q  <= grant_id ? req1_b : req0_b;
                id_q <= grant_id;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                cc_q     <= alu_cc;
            end
        end
    end

    alu_core #(.W(W)) u_alu_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .cc_o     (alu_cc)
    );

    // id_q can only change on a transfer in IDLE, so it is stable in DONE.
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_cc     = cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: expected responses are computed by a
// local reference model when a request transfers, queued, and compared when
// the response handshake completes.
module tb_alu_arbiter;

    localparam int W = 64;
    localparam logic [W-1:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, AND = 2'd2, XOR = 2'd3;

    typedef struct packed {
        logic         id;
        logic [W-1:0] result;
        logic [2:0]   cc;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_id;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_cc;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cc     (rsp_cc)
    );

    // Reference model: returns {result, ZF, SF, OF}.
    function automatic logic [W+2:0] model(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         of;
        of = 1'b0;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            default: r = a ^ b;
        endcase
        if (op == ADD) of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        if (op == SUB) of = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return {r, (r == '0), r[W-1], of};
    endfunction

    task automatic drive_req(input bit id, input bit v, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Presents a request, waits (bounded) for its ready, lets it transfer,
    // queues the expected response. Returns one time unit after the transfer
    // edge with valid dropped; waits = idle cycles spent before the grant.
    task automatic issue(input bit id, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         output int waits);
        logic rdy;
        waits = 0;
        drive_req(id, 1'b1, op, a, b);
        #1;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && waits < 20) begin
            @(posedge clk); #1;
            waits++;
            rdy = id ? req1_ready : req0_ready;
        end
        if (!rdy) begin
            n_vec++; n_bad++;
            $display("FAIL grant_timeout: req%0d ready=%b after %0d cycles, required 1", id, rdy, waits);
            drive_req(id, 1'b0, op, a, b);
            return;
        end
        @(posedge clk);
        sb.push_back({id, model(op, a, b)});
        #1;
        drive_req(id, 1'b0, op, a, b);
    endtask

    // Waits (bounded) for a response, holds rsp_ready low for 'hold' cycles
    // checking stability and that no request is accepted, then handshakes
    // and compares against the oldest queued expectation.
    task automatic collect(input int hold);
        rsp_t cap, exp;
        int   k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, k);
            return;
        end
        cap = {rsp_id, rsp_result, rsp_cc};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_cc} !== {1'b1, cap} ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable: cycle %0d valid=%b id=%b res=%h cc=%b rdy=%b%b, required 1 %b %h %b rdy=00",
                         i, rsp_valid, rsp_id, rsp_result, rsp_cc, req0_ready, req1_ready,
                         cap.id, cap.result, cap.cc);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rsp_release: rsp_valid=%b after handshake, required 0", rsp_valid);
        end
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rsp: id=%b res=%h cc=%b, required no response", cap.id, cap.result, cap.cc);
            return;
        end
        exp = sb.pop_front();
        if (cap !== exp) begin
            n_bad++;
            $display("FAIL rsp_data: id=%b res=%h cc=%b, required id=%b res=%h cc=%b",
                     cap.id, cap.result, cap.cc, exp.id, exp.result, exp.cc);
        end
    endtask

    // Both requesters valid with identical operations; expects req0 first.
    task automatic both_pair(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int w;
        drive_req(1'b0, 1'b1, op, a, b);
        drive_req(1'b1, 1'b1, op, a, b);
        #1;
        n_vec++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL tie_first: ready=%b%b (req0,req1), required 10", req0_ready, req1_ready);
        end
        issue(1'b0, op, a, b, w);
        collect(0);
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL tie_second: req1_ready=%b in IDLE after handshake, required 1", req1_ready);
        end
        issue(1'b1, op, a, b, w);
        collect(0);
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_cc} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b id=%b res=%h cc=%b, required all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_cc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_and();
        int w;
        issue(1'b0, AND, MIN_NEG, MIN_NEG, w);
        n_vec++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL first_edge_accept: waited %0d cycles, required 0", w);
        end
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_exec: rsp_valid=%b after transfer edge, required 0", rsp_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_done: rsp_valid=%b on second edge, required 1", rsp_valid);
        end
        collect(0);
        issue(1'b1, AND, MAX_POS, MIN_NEG, w);
        collect(0);
    endtask

    task automatic test_arith();
        int w;
        issue(1'b0, ADD, MAX_POS, 64'd1, w);   collect(0);
        issue(1'b1, SUB, MIN_NEG, 64'd1, w);   collect(0);
        issue(1'b0, ADD, MIN_NEG, MIN_NEG, w); collect(0);
        issue(1'b1, SUB, 64'd5, 64'd5, w);     collect(0);
        issue(1'b0, XOR, 64'hF0F0, 64'h0FF0, w); collect(0);
        for (int i = 0; i < 12; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, {$urandom, $urandom}, w);
            collect(0);
        end
    endtask

    task automatic test_both_valid();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        both_pair(AND, '1, MIN_NEG);
    endtask

    task automatic test_back_to_back();
        int w;
        issue(1'b0, SUB, 64'd100, 64'd300, w);
        drive_req(1'b1, 1'b1, ADD, 64'd7, 64'd9);
        collect(3);
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL grant_after_handshake: req1_ready=%b, required 1", req1_ready);
        end
        issue(1'b1, ADD, 64'd7, 64'd9, w);
        n_vec++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL back_to_back_gap: waited %0d extra cycles, required 0", w);
        end
        collect(0);
    endtask

    task automatic test_reset_mid_exec();
        int w;
        issue(1'b0, XOR, 64'h1234, 64'hFFFF, w);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_cc} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b id=%b res=%h cc=%b, required all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_cc);
        end
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL discarded_op: rsp_valid=%b %0d cycles after reset, required 0", rsp_valid, i);
            end
        end
        both_pair(ADD, 64'd1, 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_and();
        test_arith();
        test_both_valid();
        test_back_to_back();
        test_reset_mid_exec();
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
